// File: rtl/cp0.sv
// Coprocessor 0 for the multi-cycle MIPS core: SR/Cause/EPC/PRId, a Count/Compare
// timer, mfc0/mtc0 access, and the interrupt request sent to the controller.
module cp0 #(
  parameter logic [31:0] PRID_VALUE = 32'h2024_0131,
  parameter int          TIMER_IP   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] PC,
  input  logic [31:0] DIn,
  input  logic        Wen,
  input  logic [4:0]  SEL,
  input  logic        EXLSet,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic [31:0] Dout,
  output logic        Intreq,
  output logic [31:2] EPC
);

  localparam logic [4:0] SEL_COUNT   = 5'd9;
  localparam logic [4:0] SEL_COMPARE = 5'd11;
  localparam logic [4:0] SEL_SR      = 5'd12;
  localparam logic [4:0] SEL_CAUSE   = 5'd13;
  localparam logic [4:0] SEL_EPC     = 5'd14;
  localparam logic [4:0] SEL_PRID    = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic        ti;
  logic [29:0] epc_q;
  logic [31:0] count;
  logic [31:0] compare;
  logic [5:0]  timer_vec;

  logic wr_sr;
  logic wr_epc;
  logic wr_count;
  logic wr_compare;
  logic timer_match;

  assign wr_sr       = Wen && (SEL == SEL_SR);
  assign wr_epc      = Wen && (SEL == SEL_EPC);
  assign wr_count    = Wen && (SEL == SEL_COUNT);
  assign wr_compare  = Wen && (SEL == SEL_COMPARE);
  assign timer_match = (count == compare) && (compare != 32'd0);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    timer_vec           = '0;
    timer_vec[TIMER_IP] = ti;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      ip      <= '0;
      ti      <= 1'b0;
      epc_q   <= '0;
      count   <= '0;
      compare <= '0;
    end else begin
      // IP lags TI by one edge: the timer reaches Intreq two edges after the match.
      ip <= HWInt | timer_vec;

      if (wr_sr) begin
        im <= DIn[15:10];
        ie <= DIn[0];
      end

      // Exception entry beats eret, which beats a software write of EXL.
      if (EXLSet)      exl <= 1'b1;
      else if (EXLClr) exl <= 1'b0;
      else if (wr_sr)  exl <= DIn[1];

      if (EXLSet)      epc_q <= PC;
      else if (wr_epc) epc_q <= DIn[31:2];

      if (wr_count) count <= DIn;
      else          count <= count + 32'd1;

      if (wr_compare) compare <= DIn;

      // A Compare write acknowledges the timer even if the new value matches Count.
      if (wr_compare)       ti <= 1'b0;
      else if (timer_match) ti <= 1'b1;
    end
  end

  always_comb begin
    Dout = '0;
    case (SEL)
      SEL_COUNT:   Dout = count;
      SEL_COMPARE: Dout = compare;
      SEL_SR:      Dout = {16'd0, im, 8'd0, exl, ie};
      SEL_CAUSE:   Dout = {16'd0, ip, 10'd0};
      SEL_EPC:     Dout = {epc_q, 2'b00};
      SEL_PRID:    Dout = PRID_VALUE;
      default:     Dout = '0;
    endcase
  end

  assign Intreq = (|(ip & im)) & ie & ~exl;
  assign EPC    = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: expected values are queued as stimulus is applied and
// popped when the corresponding DUT output is sampled one time unit after the edge.
module tb_cp0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] PC;
  logic [31:0] DIn;
  logic        Wen;
  logic [4:0]  SEL;
  logic        EXLSet;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] Dout;
  logic        Intreq;
  logic [31:2] EPC;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  cp0 dut (
    .clk    (clk),
    .rst    (rst),
    .PC     (PC),
    .DIn    (DIn),
    .Wen    (Wen),
    .SEL    (SEL),
    .EXLSet (EXLSet),
    .EXLClr (EXLClr),
    .HWInt  (HWInt),
    .Dout   (Dout),
    .Intreq (Intreq),
    .EPC    (EPC)
  );

  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] sel, input logic [31:0] e);
    SEL = sel;
    exp_q.push_back(e);
    #1;
    check(tag, Dout);
  endtask

  task automatic irq(input string tag, input logic e);
    exp_q.push_back({31'd0, e});
    check(tag, {31'd0, Intreq});
  endtask

  task automatic epc_port(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    check(tag, {EPC, 2'b00});
  endtask

  task automatic wr(input logic [4:0] sel, input logic [31:0] data);
    SEL = sel;
    DIn = data;
    Wen = 1'b1;
    step();
    Wen = 1'b0;
  endtask

  initial begin
    rst = 1'b0; PC = '0; DIn = '0; Wen = 1'b0; SEL = 5'd12;
    EXLSet = 1'b0; EXLClr = 1'b0; HWInt = '0;

    // Power-on reset
    step();
    step();
    rd("por_sr", 5'd12, 32'h0);
    irq("por_intreq", 1'b0);
    epc_port("por_epc", 32'h0);
    rd("por_count", 5'd9, 32'h0);
    rd("por_prid", 5'd15, 32'h2024_0131);
    rst = 1'b1;
    step();
    rd("count_first_inc", 5'd9, 32'd1);

    // Device interrupt, exception entry, eret with line still high
    wr(5'd12, 32'h0000_0401);
    HWInt = 6'b000001;
    irq("hw_not_yet", 1'b0);
    step();
    rd("hw_cause", 5'd13, 32'h0000_0400);
    irq("hw_intreq", 1'b1);
    EXLSet = 1'b1; PC = 30'h0000_0C01;
    step();
    EXLSet = 1'b0;
    rd("exl_epc_rd", 5'd14, 32'h0000_3004);
    epc_port("exl_epc_port", 32'h0000_3004);
    irq("exl_masks", 1'b0);
    rd("exl_sr", 5'd12, 32'h0000_0403);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    irq("eret_reassert", 1'b1);
    rd("eret_sr", 5'd12, 32'h0000_0401);

    // Masking
    HWInt = 6'b000010;
    wr(5'd12, 32'h0000_0401);
    irq("mask_blocked0", 1'b0);
    step();
    irq("mask_blocked1", 1'b0);
    rd("mask_cause", 5'd13, 32'h0000_0800);
    wr(5'd12, 32'h0000_0C01);
    irq("mask_enable", 1'b1);
    HWInt = 6'b000000;
    step();
    irq("hw_drop", 1'b0);

    // Timer
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'd0);
    rd("tmr_count0", 5'd9, 32'd0);
    wr(5'd11, 32'd10);
    rd("tmr_compare", 5'd11, 32'd10);
    rd("tmr_count1", 5'd9, 32'd1);
    repeat (9) step();
    rd("tmr_count10", 5'd9, 32'd10);
    irq("tmr_match_no_irq", 1'b0);
    step();
    rd("tmr_ti_no_ip", 5'd13, 32'h0);
    irq("tmr_ti_no_irq", 1'b0);
    step();
    rd("tmr_ip", 5'd13, 32'h0000_8000);
    irq("tmr_irq", 1'b1);
    wr(5'd11, 32'd100);
    irq("tmr_ack_lag", 1'b1);
    step();
    irq("tmr_ack_drop", 1'b0);
    rd("tmr_ack_cause", 5'd13, 32'h0);
    wr(5'd11, 32'd0);

    // Collisions
    EXLSet = 1'b1; EXLClr = 1'b1; PC = 30'h100;
    wr(5'd14, 32'hDEAD_BEE0);
    EXLSet = 1'b0; EXLClr = 1'b0;
    rd("col_epc_rd", 5'd14, 32'h0000_0400);
    epc_port("col_epc_port", 32'h0000_0400);
    rd("col_sr_exl", 5'd12, 32'h0000_8003);
    EXLClr = 1'b1;
    wr(5'd12, 32'h0000_0C03);
    EXLClr = 1'b0;
    rd("col_clr_wsr", 5'd12, 32'h0000_0C01);
    EXLSet = 1'b1; PC = 30'h2;
    wr(5'd12, 32'h0000_0800);
    EXLSet = 1'b0;
    rd("col_set_wsr", 5'd12, 32'h0000_0802);
    rd("col_set_epc", 5'd14, 32'h0000_0008);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    wr(5'd9, 32'hFFFF_FFFF);
    rd("wrap_pre", 5'd9, 32'hFFFF_FFFF);
    step();
    rd("wrap_post", 5'd9, 32'h0);

    // Unmapped and read-only
    wr(5'd5, 32'hFFFF_FFFF);
    rd("unmapped_rd", 5'd5, 32'h0);
    rd("unmapped_sr", 5'd12, 32'h0000_0800);
    rd("unmapped_epc", 5'd14, 32'h0000_0008);
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0);
    rd("cause_ro_cmp", 5'd11, 32'h0);

    // Asynchronous reset mid-run
    wr(5'd9, 32'h0000_0055);
    rd("pre_rst_count", 5'd9, 32'h0000_0055);
    EXLSet = 1'b1; PC = 30'h3FF;
    step();
    EXLSet = 1'b0;
    rd("pre_rst_sr", 5'd12, 32'h0000_0802);
    #2 rst = 1'b0;
    rd("rst_sr", 5'd12, 32'h0);
    irq("rst_intreq", 1'b0);
    epc_port("rst_epc", 32'h0);
    rd("rst_count", 5'd9, 32'h0);
    rd("rst_prid", 5'd15, 32'h2024_0131);
    step();
    rd("rst_hold_count", 5'd9, 32'h0);
    rst = 1'b1;
    step();
    rd("rst_release_inc", 5'd9, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
